// File: rtl/mul_seq_arbiter.sv
// Two-requester round-robin front end for a sequential shift-add multiplier.
// Accepts one request at a time in IDLE, steps the multiplier ITER times,
// captures the product and holds it on a valid/ready response port.
module mul_seq_arbiter #(
   parameter int unsigned ITER      = 32,
   parameter logic [5:0]  SIG_MULTU = 6'b011001,
   parameter logic [5:0]  SIG_OUT   = 6'b111111,
   parameter logic [5:0]  SIG_IDLE  = 6'b000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   output logic        ack0,
   output logic        ack1,
   output logic        mul_rst,
   output logic [5:0]  mul_signal,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [63:0] mul_product,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [63:0] rsp_data,
   input  logic        rsp_ready,
   output logic        busy
);

   localparam int unsigned CNT_W = 6;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_CAPTURE,
      S_RESP
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             prio;
   logic             grant;
   logic             any_req;

   // Round-robin pick: a lone requester wins, a tie goes to the priority holder.
   always_comb begin
      any_req = req0 | req1;
      grant   = (req0 && req1) ? prio : req1;
   end

   // State, step counter, arbitration pointer, operand and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         prio     <= 1'b0;
         mul_a    <= '0;
         mul_b    <= '0;
         rsp_id   <= 1'b0;
         rsp_data <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && any_req) begin
            rsp_id <= grant;
            mul_a  <= grant ? a1 : a0;
            mul_b  <= grant ? b1 : b0;
            prio   <= ~grant;
         end
         if (state == S_LOAD) begin
            cnt <= '0;
         end else if (state == S_RUN) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (state == S_CAPTURE) begin
            rsp_data <= mul_product;
         end
      end
   end

   // Next-state and state-decoded outputs; reset forces the idle output set.
   always_comb begin
      state_nxt  = state;
      ack0       = 1'b0;
      ack1       = 1'b0;
      mul_rst    = 1'b0;
      mul_signal = SIG_IDLE;
      rsp_valid  = 1'b0;
      busy       = 1'b0;
      if (reset) begin
         mul_rst = 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               mul_rst = 1'b1;
               if (any_req) state_nxt = S_LOAD;
            end
            S_LOAD: begin
               busy      = 1'b1;
               mul_rst   = 1'b1;
               ack0      = ~rsp_id;
               ack1      = rsp_id;
               state_nxt = S_RUN;
            end
            S_RUN: begin
               busy       = 1'b1;
               mul_signal = SIG_MULTU;
               if (cnt == CNT_LAST) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
               busy      = 1'b1;
               state_nxt = S_RESP;
            end
            S_RESP: begin
               busy      = 1'b1;
               rsp_valid = 1'b1;
               if (rsp_ready) begin
                  mul_signal = SIG_OUT;
                  state_nxt  = S_IDLE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_seq_arbiter.sv
// Directed bench for mul_seq_arbiter with a behavioural shift-add multiplier.
module tb_mul_seq_arbiter;

   localparam logic [5:0] SIG_MULTU = 6'b011001;
   localparam logic [5:0] SIG_OUT   = 6'b111111;
   localparam logic [5:0] SIG_IDLE  = 6'b000000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic        ack0, ack1, mul_rst, rsp_valid, rsp_id, busy;
   logic [5:0]  mul_signal;
   logic [31:0] mul_a, mul_b;
   logic [63:0] mul_product, rsp_data;
   logic        rsp_ready = 1'b1;

   int checks = 0;
   int errors = 0;

   mul_seq_arbiter dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .ack0(ack0), .ack1(ack1),
      .mul_rst(mul_rst), .mul_signal(mul_signal), .mul_a(mul_a), .mul_b(mul_b),
      .mul_product(mul_product), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   // External multiplier: loads on mul_rst, one shift-add per SIG_MULTU cycle.
   logic [63:0] m_acc, m_sa;
   logic [31:0] m_sb;
   always @(posedge clk) begin
      if (mul_rst || mul_signal == SIG_OUT) begin
         m_acc <= '0;
         m_sa  <= {32'd0, mul_a};
         m_sb  <= mul_b;
      end else if (mul_signal == SIG_MULTU) begin
         if (m_sb[0]) m_acc <= m_acc + m_sa;
         m_sa <= m_sa << 1;
         m_sb <= m_sb >> 1;
      end
   end
   assign mul_product = m_acc;

   // Runs one transaction and reports what was observed.
   task automatic do_txn(input logic r0, input logic r1,
                         input logic [31:0] xa0, input logic [31:0] xb0,
                         input logic [31:0] xa1, input logic [31:0] xb1,
                         input int hold,
                         output logic oid, output logic [63:0] odata,
                         output int olat, output int omultu,
                         output int oack0, output int oack1, output int osigout,
                         output logic ostable, output logic oto);
      int resp_n;
      logic done, saw0, saw1;
      oid = 0; odata = '0; olat = -1; omultu = 0; oack0 = 0; oack1 = 0;
      osigout = 0; ostable = 1; oto = 1; resp_n = 0; done = 0;
      @(posedge clk); #1;
      req0 = r0; req1 = r1; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
      rsp_ready = (hold == 0);
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         @(negedge clk);
         saw0 = ack0; saw1 = ack1;
         if (ack0) oack0++;
         if (ack1) oack1++;
         if (mul_signal == SIG_MULTU) omultu++;
         if (mul_signal == SIG_OUT) osigout++;
         if (rsp_valid) begin
            if (olat < 0) begin
               olat = cyc; oid = rsp_id; odata = rsp_data;
            end else if (rsp_data !== odata || rsp_id !== oid) begin
               ostable = 0;
            end
            if (!busy || ack0 || ack1) ostable = 0;
            if (rsp_ready) begin done = 1; oto = 0; end
            resp_n++;
         end
         if (!done) begin
            @(posedge clk); #1;
            if (saw0) req0 = 0;
            if (saw1) req1 = 0;
            if (resp_n >= hold) rsp_ready = 1;
         end
      end
      if (oto) begin req0 = 0; req1 = 0; end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1; req0 = 0; req1 = 0; rsp_ready = 1;
      @(posedge clk); @(posedge clk); #1;
      reset = 0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if ({ack0, ack1} !== 2'b00) begin errors++; $display("FAIL reset_acks got %b want 00", {ack0, ack1}); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      checks++; if (mul_signal !== SIG_IDLE) begin errors++; $display("FAIL reset_mul_signal got %h want %h", mul_signal, SIG_IDLE); end
      checks++; if (mul_rst !== 1'b1) begin errors++; $display("FAIL reset_mul_rst got %b want 1", mul_rst); end
      checks++; if (rsp_data !== 64'd0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
      checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %b want 0", rsp_id); end
      checks++; if ({mul_a, mul_b} !== 64'd0) begin errors++; $display("FAIL reset_operands got %h want 0", {mul_a, mul_b}); end
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy %b valid %b want 0 0", busy, rsp_valid); end
   endtask

   task automatic test_basic();
      logic id, st, to; logic [63:0] d; int lat, mu, k0, k1, so;
      do_txn(1, 0, 32'd3, 32'd5, 32'd0, 32'd0, 0, id, d, lat, mu, k0, k1, so, st, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b want 0", to); end
      checks++; if (k0 != 1 || k1 != 0) begin errors++; $display("FAIL basic_acks got %0d/%0d want 1/0", k0, k1); end
      checks++; if (mu != 32) begin errors++; $display("FAIL basic_multu_cycles got %0d want 32", mu); end
      checks++; if (lat != 35) begin errors++; $display("FAIL basic_latency got %0d want 35", lat); end
      checks++; if (d !== 64'd15) begin errors++; $display("FAIL basic_data got %0d want 15", d); end
      checks++; if (id !== 1'b0) begin errors++; $display("FAIL basic_id got %b want 0", id); end
      checks++; if (so != 1) begin errors++; $display("FAIL basic_sig_out got %0d want 1", so); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_back_idle got busy %b want 0", busy); end
   endtask

   task automatic test_arbitration();
      logic id, st, to; logic [63:0] d; int lat, mu, k0, k1, so;
      do_reset();
      do_txn(1, 1, 32'd2, 32'd7, 32'd4, 32'd9, 0, id, d, lat, mu, k0, k1, so, st, to);
      checks++; if (id !== 1'b0 || d !== 64'd14 || to) begin errors++; $display("FAIL arb_first got id %b data %0d want id 0 data 14", id, d); end
      checks++; if (k0 != 1 || k1 != 0) begin errors++; $display("FAIL arb_first_acks got %0d/%0d want 1/0", k0, k1); end
      do_txn(0, 1, 32'd2, 32'd7, 32'd4, 32'd9, 0, id, d, lat, mu, k0, k1, so, st, to);
      checks++; if (id !== 1'b1 || d !== 64'd36 || to) begin errors++; $display("FAIL arb_second got id %b data %0d want id 1 data 36", id, d); end
      checks++; if (k0 != 0 || k1 != 1 || lat != 35) begin errors++; $display("FAIL arb_second_acks got %0d/%0d lat %0d want 0/1 lat 35", k0, k1, lat); end
      do_txn(1, 1, 32'd2, 32'd7, 32'd4, 32'd9, 0, id, d, lat, mu, k0, k1, so, st, to);
      checks++; if (id !== 1'b0 || d !== 64'd14 || to) begin errors++; $display("FAIL arb_third got id %b data %0d want id 0 data 14", id, d); end
      do_txn(0, 1, 32'd2, 32'd7, 32'd4, 32'd9, 0, id, d, lat, mu, k0, k1, so, st, to);
      checks++; if (id !== 1'b1 || d !== 64'd36 || to) begin errors++; $display("FAIL arb_fourth got id %b data %0d want id 1 data 36", id, d); end
   endtask

   task automatic test_maxval();
      logic id, st, to; logic [63:0] d; int lat, mu, k0, k1, so;
      do_txn(0, 1, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, id, d, lat, mu, k0, k1, so, st, to);
      checks++; if (d !== 64'hFFFFFFFE00000001 || to) begin errors++; $display("FAIL maxval_data got %h want fffffffe00000001", d); end
      checks++; if (id !== 1'b1) begin errors++; $display("FAIL maxval_id got %b want 1", id); end
   endtask

   task automatic test_backpressure();
      logic id, st, to; logic [63:0] d; int lat, mu, k0, k1, so;
      do_txn(1, 0, 32'd100, 32'd200, 32'd0, 32'd0, 10, id, d, lat, mu, k0, k1, so, st, to);
      checks++; if (d !== 64'd20000 || to) begin errors++; $display("FAIL bp_data got %0d want 20000", d); end
      checks++; if (st !== 1'b1) begin errors++; $display("FAIL bp_stable got %b want 1", st); end
      checks++; if (k0 != 1 || k1 != 0) begin errors++; $display("FAIL bp_acks got %0d/%0d want 1/0", k0, k1); end
      checks++; if (so != 1) begin errors++; $display("FAIL bp_sig_out got %0d want 1", so); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || mul_signal !== SIG_IDLE) begin errors++; $display("FAIL bp_idle got busy %b sig %h want 0 %h", busy, mul_signal, SIG_IDLE); end
   endtask

   task automatic test_reset_mid_run();
      logic id, st, to; logic [63:0] d; int lat, mu, k0, k1, so;
      int steps; logic got_ack; logic bad;
      @(posedge clk); #1;
      req0 = 1; a0 = 32'd6; b0 = 32'd7; rsp_ready = 1;
      got_ack = 0;
      for (int i = 0; i < 10 && !got_ack; i++) begin
         @(negedge clk);
         if (ack0) got_ack = 1;
      end
      checks++; if (got_ack !== 1'b1) begin errors++; $display("FAIL midrun_ack got %b want 1", got_ack); end
      @(posedge clk); #1;
      req0 = 0;
      steps = 0;
      for (int i = 0; i < 50 && steps < 10; i++) begin
         @(negedge clk);
         if (mul_signal == SIG_MULTU) steps++;
         if (steps < 10) begin @(posedge clk); #1; end
      end
      checks++; if (steps != 10) begin errors++; $display("FAIL midrun_steps got %0d want 10", steps); end
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); @(negedge clk);
      checks++; if (busy !== 1'b0 || mul_rst !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL midrun_reset got busy %b rst %b valid %b want 0 1 0", busy, mul_rst, rsp_valid); end
      @(posedge clk); #1;
      reset = 0;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rsp_valid || busy) bad = 1;
      end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL midrun_abandoned got activity %b want 0", bad); end
      do_txn(1, 0, 32'd11, 32'd13, 32'd0, 32'd0, 0, id, d, lat, mu, k0, k1, so, st, to);
      checks++; if (d !== 64'd143 || id !== 1'b0 || to) begin errors++; $display("FAIL midrun_after got %0d id %b want 143 id 0", d, id); end
   endtask

   task automatic test_zero();
      logic id, st, to; logic [63:0] d; int lat, mu, k0, k1, so;
      do_txn(1, 0, 32'd0, 32'd12345, 32'd0, 32'd0, 0, id, d, lat, mu, k0, k1, so, st, to);
      checks++; if (d !== 64'd0 || to) begin errors++; $display("FAIL zero_a_data got %0d want 0", d); end
      checks++; if (lat != 35) begin errors++; $display("FAIL zero_a_latency got %0d want 35", lat); end
      do_txn(1, 0, 32'd7, 32'd0, 32'd0, 32'd0, 0, id, d, lat, mu, k0, k1, so, st, to);
      checks++; if (d !== 64'd0 || to) begin errors++; $display("FAIL zero_b_data got %0d want 0", d); end
      checks++; if (lat != 35) begin errors++; $display("FAIL zero_b_latency got %0d want 35", lat); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_arbitration();
      test_maxval();
      test_backpressure();
      test_reset_mid_run();
      test_zero();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
